// File: rtl/cache_access_sequencer_pkg.sv
// Shared types and defaults for the CPU-to-L1 access sequencer.
// State encoding, address split, timeout and strobe constants live here.
package cache_access_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_RD   = 3'd1,
    D_RD   = 3'd2,
    RMW_RD = 3'd3,
    D_WR   = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [31:0] END_INST_DEFAULT = 32'h0001_1fd8;
  localparam int          TIMEOUT_DEFAULT  = 1024;
  localparam logic [3:0]  STRB_FULL        = 4'b1111;
  localparam logic [3:0]  STRB_NONE        = 4'b0000;

endpackage

// File: rtl/cache_access_sequencer_store_byte_merge.sv
// Byte-lane merge for sub-word stores: enabled lanes take the new word,
// the remaining lanes keep the word read back from L1D.
module store_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  strobe,
  output logic [31:0] merged_word
);

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strobe[i]) merged_word[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/cache_access_sequencer.sv
// Routes rvsteel_core IO requests to L1I or L1D by address, turns sub-word
// stores into L1D read-modify-write, and answers each request with one pulse.
module cache_access_sequencer
  import cache_access_sequencer_pkg::*;
#(
  parameter logic [31:0] END_INST = END_INST_DEFAULT,
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] rw_address,
  input  logic        read_request,
  input  logic        write_request,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  output logic [31:0] read_data,
  output logic        read_response,
  output logic        write_response,
  output logic [31:0] address_L1,
  output logic        read_C_L1I,
  input  logic [31:0] read_data_L1I_C,
  input  logic        ready_L1I_C,
  output logic        read_C_L1D,
  output logic        write_C_L1D,
  output logic [31:0] write_data_C_L1,
  input  logic [31:0] read_data_L1D_C,
  input  logic        ready_L1D_C,
  input  logic        write_response_L1D,
  output logic        illegal_write,
  output logic        timeout_err,
  output state_t      state_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   addr_q, wr_word, merged_word;
  logic [3:0]    strb_q;
  logic          is_write, merged_q;
  logic          resp_busy, accept, accept_write, in_inst, waiting, cnt_expired;

  // CPU handshake: a request is a level held until its response pulse; the
  // pulse cycle itself must not re-accept the still-held request.
  assign resp_busy    = read_response | write_response;
  assign accept       = (read_request | write_request) & ~resp_busy;
  assign accept_write = write_request & ~resp_busy;
  assign in_inst      = (rw_address <= END_INST);
  assign cnt_expired  = (wait_cnt == CW'(TIMEOUT - 1));
  assign waiting      = (state == I_RD) || (state == D_RD) || (state == D_WR) ||
                        ((state == RMW_RD) && !merged_q);

  assign address_L1      = addr_q;
  assign write_data_C_L1 = wr_word;
  assign state_dbg       = state;

  store_byte_merge u_merge (
    .old_word    (read_data_L1D_C),
    .new_word    (wr_word),
    .strobe      (strb_q),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    read_C_L1I  = 1'b0;
    read_C_L1D  = 1'b0;
    write_C_L1D = 1'b0;
    case (state)
      IDLE: begin
        if (accept_write) begin
          if (in_inst || (write_strobe == STRB_NONE)) state_next = RESP;
          else if (write_strobe == STRB_FULL)         state_next = D_WR;
          else                                        state_next = RMW_RD;
        end else if (accept) begin
          state_next = in_inst ? I_RD : D_RD;
        end
      end
      I_RD: begin
        read_C_L1I = 1'b1;
        if (ready_L1I_C || cnt_expired) state_next = RESP;
      end
      D_RD: begin
        read_C_L1D = 1'b1;
        if (ready_L1D_C || cnt_expired) state_next = RESP;
      end
      RMW_RD: begin
        // After the read returns, one idle cycle holds the registered merge.
        if (merged_q) begin
          state_next = D_WR;
        end else begin
          read_C_L1D = 1'b1;
          if (!ready_L1D_C && cnt_expired) state_next = RESP;
        end
      end
      D_WR: begin
        write_C_L1D = 1'b1;
        if (write_response_L1D || cnt_expired) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt       <= '0;
      addr_q         <= '0;
      wr_word        <= '0;
      strb_q         <= '0;
      is_write       <= 1'b0;
      merged_q       <= 1'b0;
      read_data      <= '0;
      read_response  <= 1'b0;
      write_response <= 1'b0;
      illegal_write  <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      wait_cnt       <= (state_next != state) ? '0 : (waiting ? wait_cnt + CW'(1) : '0);
      read_response  <= (state == RESP) && !is_write;
      write_response <= (state == RESP) && is_write;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= rw_address;
            wr_word  <= write_data;
            strb_q   <= write_strobe;
            is_write <= accept_write;
            merged_q <= 1'b0;
            if (accept_write && in_inst) illegal_write <= 1'b1;
          end
        end
        I_RD: begin
          if (ready_L1I_C) read_data <= read_data_L1I_C;
          else if (cnt_expired) begin
            read_data   <= '0;
            timeout_err <= 1'b1;
          end
        end
        D_RD: begin
          if (ready_L1D_C) read_data <= read_data_L1D_C;
          else if (cnt_expired) begin
            read_data   <= '0;
            timeout_err <= 1'b1;
          end
        end
        RMW_RD: begin
          if (!merged_q) begin
            if (ready_L1D_C) begin
              wr_word  <= merged_word;
              merged_q <= 1'b1;
            end else if (cnt_expired) begin
              timeout_err <= 1'b1;
            end
          end
        end
        D_WR: begin
          if (!write_response_L1D && cnt_expired) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_access_sequencer.sv
// Directed bench for cache_access_sequencer: cycle-counting cache models,
// a CPU driver, and a write-data scoreboard with hand-computed expectations.
module tb_cache_access_sequencer;
  import cache_access_sequencer_pkg::*;

  logic        clk, rstn;
  logic [31:0] rw_address, write_data, read_data, address_L1, write_data_C_L1;
  logic        read_request, write_request, read_response, write_response;
  logic [3:0]  write_strobe;
  logic        read_C_L1I, ready_L1I_C, read_C_L1D, write_C_L1D;
  logic [31:0] read_data_L1I_C, read_data_L1D_C;
  logic        ready_L1D_C, write_response_L1D, illegal_write, timeout_err;
  state_t      state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Cache model settings: delay 0 on the L1D read side means never ready.
  int l1i_delay, l1d_rd_delay, l1d_wr_delay;
  int i_cnt, d_cnt, w_cnt;

  int cnt_i_rd = 0, cnt_d_rd = 0, cnt_d_wr = 0;
  int cnt_rd_pulse = 0, cnt_wr_pulse = 0, cnt_excl = 0;
  int b_i_rd, b_d_rd, b_d_wr, b_rd_pulse, b_wr_pulse;

  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];
  int          wr_idx = 0;
  int          lat;

  cache_access_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .rw_address(rw_address),
    .read_request(read_request), .write_request(write_request),
    .write_data(write_data), .write_strobe(write_strobe),
    .read_data(read_data), .read_response(read_response),
    .write_response(write_response), .address_L1(address_L1),
    .read_C_L1I(read_C_L1I), .read_data_L1I_C(read_data_L1I_C),
    .ready_L1I_C(ready_L1I_C), .read_C_L1D(read_C_L1D),
    .write_C_L1D(write_C_L1D), .write_data_C_L1(write_data_C_L1),
    .read_data_L1D_C(read_data_L1D_C), .ready_L1D_C(ready_L1D_C),
    .write_response_L1D(write_response_L1D), .illegal_write(illegal_write),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  // Cache models: ready/done rises in the Nth cycle a request line is high.
  always @(negedge clk) begin
    if (read_C_L1I) begin
      i_cnt++;
      ready_L1I_C = (i_cnt == l1i_delay);
    end else begin
      i_cnt = 0;
      ready_L1I_C = 1'b0;
    end
    if (read_C_L1D) begin
      d_cnt++;
      ready_L1D_C = (l1d_rd_delay != 0) && (d_cnt == l1d_rd_delay);
    end else begin
      d_cnt = 0;
      ready_L1D_C = 1'b0;
    end
    if (write_C_L1D) begin
      w_cnt++;
      write_response_L1D = (w_cnt == l1d_wr_delay);
      if (write_response_L1D) wr_log.push_back(write_data_C_L1);
    end else begin
      w_cnt = 0;
      write_response_L1D = 1'b0;
    end
  end

  // Activity monitor
  always @(negedge clk) begin
    if (read_C_L1I)     cnt_i_rd++;
    if (read_C_L1D)     cnt_d_rd++;
    if (write_C_L1D)    cnt_d_wr++;
    if (read_response)  cnt_rd_pulse++;
    if (write_response) cnt_wr_pulse++;
    if ((32'(read_C_L1I) + 32'(read_C_L1D) + 32'(write_C_L1D)) > 1) cnt_excl++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_i_rd = cnt_i_rd; b_d_rd = cnt_d_rd; b_d_wr = cnt_d_wr;
    b_rd_pulse = cnt_rd_pulse; b_wr_pulse = cnt_wr_pulse;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a request at negedge; returns right after the acceptance edge.
  task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    @(negedge clk);
    rw_address = addr; write_data = wdata; write_strobe = strb;
    read_request = rd; write_request = wr;
    @(posedge clk);
  endtask

  // Latency = edges from acceptance to the edge where the CPU samples the pulse.
  task automatic wait_resp(input logic want_wr, input string tag, output int l);
    logic seen;
    seen = 1'b0;
    l = 0;
    while (!seen && l < 100) begin
      @(negedge clk);
      seen = want_wr ? write_response : read_response;
      @(posedge clk);
      l++;
    end
    check({tag, "_resp_seen"}, 32'(seen), 1);
    #1;
    if (want_wr) write_request = 1'b0;
    else         read_request  = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    while (exp_q.size() > 0) begin
      if (wr_idx < wr_log.size()) check({tag, "_l1d_wdata"}, wr_log[wr_idx], exp_q.pop_front());
      else begin
        check({tag, "_l1d_wr_count"}, wr_log.size(), wr_idx + 1);
        void'(exp_q.pop_front());
      end
      wr_idx++;
    end
    check({tag, "_no_extra_l1d_wr"}, wr_log.size(), wr_idx);
  endtask

  initial begin
    rstn = 1'b0; read_request = 1'b0; write_request = 1'b0;
    rw_address = '0; write_data = '0; write_strobe = '0;
    read_data_L1I_C = '0; read_data_L1D_C = '0;
    ready_L1I_C = 1'b0; ready_L1D_C = 1'b0; write_response_L1D = 1'b0;
    l1i_delay = 1; l1d_rd_delay = 1; l1d_wr_delay = 1;
    i_cnt = 0; d_cnt = 0; w_cnt = 0;
    repeat (3) @(negedge clk);

    check("rst_read_data", read_data, 32'h0);
    check("rst_responses", {30'b0, read_response, write_response}, 32'h0);
    check("rst_req_lines", {29'b0, read_C_L1I, read_C_L1D, write_C_L1D}, 32'h0);
    check("rst_flags", {30'b0, illegal_write, timeout_err}, 32'h0);
    check("rst_address_L1", address_L1, 32'h0);
    check("rst_wdata_L1", write_data_C_L1, 32'h0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rstn = 1'b1;
    idle(2);

    // L1I read, ready after 3 cycles
    l1i_delay = 3; read_data_L1I_C = 32'h0000_0413;
    snap();
    cpu_req(1'b1, 1'b0, 32'h0001_00d8, 32'h0, 4'h0);
    wait_resp(1'b0, "t1", lat);
    idle(3);
    check("t1_latency", lat, 5);
    check("t1_read_data", read_data, 32'h0000_0413);
    check("t1_l1i_cycles", cnt_i_rd - b_i_rd, 3);
    check("t1_l1d_cycles", (cnt_d_rd - b_d_rd) + (cnt_d_wr - b_d_wr), 0);
    check("t1_rd_pulses", cnt_rd_pulse - b_rd_pulse, 1);
    check("t1_wr_pulses", cnt_wr_pulse - b_wr_pulse, 0);

    // Byte store: RMW with Nr=2, Nw=3
    l1d_rd_delay = 2; read_data_L1D_C = 32'h1122_3344; l1d_wr_delay = 3;
    exp_q.push_back(32'h1122_AB44);
    snap();
    cpu_req(1'b0, 1'b1, 32'h0002_0004, 32'h0000_AB00, 4'b0010);
    wait_resp(1'b1, "t2", lat);
    idle(3);
    check("t2_latency", lat, 8);
    check("t2_l1d_rd_cycles", cnt_d_rd - b_d_rd, 2);
    check("t2_l1d_wr_cycles", cnt_d_wr - b_d_wr, 3);
    check("t2_wr_pulses", cnt_wr_pulse - b_wr_pulse, 1);
    check("t2_address_L1", address_L1, 32'h0002_0004);
    check_writes("t2");

    // Full-word store, Nw=2, no L1D read
    l1d_wr_delay = 2;
    exp_q.push_back(32'hDEAD_BEEF);
    snap();
    cpu_req(1'b0, 1'b1, 32'h0002_0008, 32'hDEAD_BEEF, 4'b1111);
    wait_resp(1'b1, "t3", lat);
    idle(3);
    check("t3_latency", lat, 4);
    check("t3_l1d_rd_cycles", cnt_d_rd - b_d_rd, 0);
    check("t3_l1d_wr_cycles", cnt_d_wr - b_d_wr, 2);
    check_writes("t3");

    // Write into the L1I region
    check("t4_illegal_before", 32'(illegal_write), 0);
    snap();
    cpu_req(1'b0, 1'b1, 32'h0001_1000, 32'h1234_5678, 4'b1111);
    wait_resp(1'b1, "t4", lat);
    idle(3);
    check("t4_latency", lat, 2);
    check("t4_cache_cycles", (cnt_i_rd - b_i_rd) + (cnt_d_rd - b_d_rd) + (cnt_d_wr - b_d_wr), 0);
    check("t4_illegal_write", 32'(illegal_write), 1);
    check("t4_wr_pulses", cnt_wr_pulse - b_wr_pulse, 1);
    check_writes("t4");

    // Zero-strobe write to L1D
    snap();
    cpu_req(1'b0, 1'b1, 32'h0002_0010, 32'hFFFF_FFFF, 4'b0000);
    wait_resp(1'b1, "t4b", lat);
    idle(2);
    check("t4b_latency", lat, 2);
    check("t4b_cache_cycles", (cnt_d_rd - b_d_rd) + (cnt_d_wr - b_d_wr), 0);
    check_writes("t4b");

    // Address split boundary: END_INST itself is L1I, next word is L1D
    l1i_delay = 1; read_data_L1I_C = 32'h0000_0A0A;
    snap();
    cpu_req(1'b1, 1'b0, 32'h0001_1fd8, 32'h0, 4'h0);
    wait_resp(1'b0, "tb_lo", lat);
    idle(2);
    check("tb_lo_latency", lat, 3);
    check("tb_lo_l1i_cycles", cnt_i_rd - b_i_rd, 1);
    check("tb_lo_l1d_cycles", cnt_d_rd - b_d_rd, 0);
    check("tb_lo_read_data", read_data, 32'h0000_0A0A);
    l1d_rd_delay = 1; read_data_L1D_C = 32'h0000_0B0B;
    snap();
    cpu_req(1'b1, 1'b0, 32'h0001_1fdc, 32'h0, 4'h0);
    wait_resp(1'b0, "tb_hi", lat);
    idle(2);
    check("tb_hi_l1i_cycles", cnt_i_rd - b_i_rd, 0);
    check("tb_hi_l1d_cycles", cnt_d_rd - b_d_rd, 1);
    check("tb_hi_read_data", read_data, 32'h0000_0B0B);

    // Simultaneous read and write: write first, then the held read
    l1d_wr_delay = 1; l1d_rd_delay = 2; read_data_L1D_C = 32'hCAFE_F00D;
    exp_q.push_back(32'h55AA_55AA);
    snap();
    cpu_req(1'b1, 1'b1, 32'h0002_0000, 32'h55AA_55AA, 4'b1111);
    wait_resp(1'b1, "t5w", lat);
    check("t5_wr_latency", lat, 3);
    check("t5_no_rd_yet", cnt_rd_pulse - b_rd_pulse, 0);
    cpu_req(1'b1, 1'b0, 32'h0002_0000, 32'h55AA_55AA, 4'b1111);
    wait_resp(1'b0, "t5r", lat);
    idle(3);
    check("t5_rd_latency", lat, 4);
    check("t5_read_data", read_data, 32'hCAFE_F00D);
    check("t5_rd_pulses", cnt_rd_pulse - b_rd_pulse, 1);
    check("t5_wr_pulses", cnt_wr_pulse - b_wr_pulse, 1);
    check("t5_l1d_rd_cycles", cnt_d_rd - b_d_rd, 2);
    check_writes("t5");

    // L1D never ready: abort after 16 waiting cycles
    l1d_rd_delay = 0;
    check("t6_timeout_before", 32'(timeout_err), 0);
    snap();
    cpu_req(1'b1, 1'b0, 32'h0002_0000, 32'h0, 4'h0);
    wait_resp(1'b0, "t6", lat);
    idle(3);
    check("t6_latency", lat, 18);
    check("t6_l1d_rd_cycles", cnt_d_rd - b_d_rd, 16);
    check("t6_timeout_err", 32'(timeout_err), 1);
    check("t6_read_data", read_data, 32'h0);
    check("t6_rd_pulses", cnt_rd_pulse - b_rd_pulse, 1);

    // Reset while waiting in RMW_RD
    l1d_rd_delay = 10;
    cpu_req(1'b0, 1'b1, 32'h0002_0004, 32'h0000_00EE, 4'b0001);
    repeat (3) @(posedge clk);
    #2;
    check("t7_in_rmw_rd", 32'(state_dbg), 32'(RMW_RD));
    check("t7_rd_level_before", 32'(read_C_L1D), 1);
    rstn = 1'b0;
    #1;
    check("t7_rd_level_async", 32'(read_C_L1D), 0);
    check("t7_state_async", 32'(state_dbg), 32'(IDLE));
    check("t7_flags_cleared", {30'b0, illegal_write, timeout_err}, 32'h0);
    check("t7_addr_cleared", address_L1, 32'h0);
    write_request = 1'b0;
    snap();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(5);
    check("t7_no_pulses", (cnt_rd_pulse - b_rd_pulse) + (cnt_wr_pulse - b_wr_pulse), 0);
    check("t7_no_l1d_wr", cnt_d_wr - b_d_wr, 0);
    l1i_delay = 1; read_data_L1I_C = 32'h0000_0513;
    snap();
    cpu_req(1'b1, 1'b0, 32'h0001_00d8, 32'h0, 4'h0);
    wait_resp(1'b0, "t7r", lat);
    idle(2);
    check("t7_after_latency", lat, 3);
    check("t7_after_read_data", read_data, 32'h0000_0513);
    check("t7_after_rd_pulses", cnt_rd_pulse - b_rd_pulse, 1);
    check_writes("t7");

    check("req_lines_exclusive", cnt_excl, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_access_sequencer.md
Name: cache_access_sequencer

Overview:
- Sits between the rvsteel_core IO interface and the L1I/L1D ports of the cache top.
- Latches each CPU request and routes it by address: at or below END_INST goes to L1I, above goes to L1D.
- Performs sub-word stores as read-modify-write on L1D, so the caches only ever see full 32-bit writes.
- Returns exactly one registered response pulse per accepted request.

Parameters:
- END_INST, 32'h11fd8, highest byte address served by L1I. Addresses above it go to L1D.
- TIMEOUT, 1024, cycles to wait for any cache ready/response before aborting the request.

Ports:
- clk  in  1  single clock for the CPU side and the cache side.
- rstn  in  1  asynchronous, active-low reset.
- rw_address  in  32  CPU byte address.
- read_request  in  1  CPU read request; held by the CPU until read_response.
- write_request  in  1  CPU write request; held by the CPU until write_response.
- write_data  in  32  CPU store data, byte-lane aligned.
- write_strobe  in  4  byte enables; bit i enables bits [8i+7:8i].
- read_data  out  32  registered load data.
- read_response  out  1  one-cycle pulse ending a read.
- write_response  out  1  one-cycle pulse ending a write.
- address_L1  out  32  latched address, driven to both address_L1I and address_L1D.
- read_C_L1I  out  1  L1I read request level.
- read_data_L1I_C  in  32  L1I read data.
- ready_L1I_C  in  1  L1I data-valid pulse.
- read_C_L1D  out  1  L1D read request level.
- write_C_L1D  out  1  L1D write request level.
- write_data_C_L1  out  32  merged full-word store data.
- read_data_L1D_C  in  32  L1D read data.
- ready_L1D_C  in  1  L1D read data-valid pulse.
- write_response_L1D  in  1  L1D write-done pulse.
- illegal_write  out  1  sticky flag: a write targeted the L1I region.
- timeout_err  out  1  sticky flag: a cache handshake exceeded TIMEOUT.

Behaviour:
- Reset: every output is 0, FSM is in IDLE, latches and the timeout counter are cleared.
- Reset asserted mid-transaction: the request is dropped immediately with no response pulse, and both cache request levels fall asynchronously.
- FSM states: IDLE, I_RD, D_RD, RMW_RD, D_WR, RESP.
- IDLE: a request is accepted on a clock edge. On acceptance the block latches rw_address, write_data and write_strobe.
  - Simultaneous read_request and write_request: the write is accepted. The read stays pending because the CPU holds it, and it is accepted after the write's RESP.
- Read, address <= END_INST: go to I_RD and hold read_C_L1I=1 until a cycle with ready_L1I_C=1. In that cycle, capture read_data_L1I_C and go to RESP.
- Read, address > END_INST: go to D_RD; same handshake as I_RD using read_C_L1D and ready_L1D_C.
- Write, address <= END_INST: no cache access. Set illegal_write and go straight to RESP.
- Write with strobe 4'b1111: go to D_WR with write_data_C_L1 = write_data and write_C_L1D=1, held until write_response_L1D.
- Write with strobe 4'b0000: no cache access; go straight to RESP.
- Write with any other strobe: go to RMW_RD and read L1D.
  - On ready_L1D_C, form the merged word per byte: enabled lanes take write_data, other lanes take read_data_L1D_C.
  - Register the merged word, then go to D_WR.
- RESP: lasts exactly one cycle. read_response or write_response pulses for that cycle, matching the accepted request type. Next state is IDLE.
- Response latency from the acceptance edge:
  - read: N+2 cycles, where N is the cache ready delay (N >= 1).
  - full-word write: N+2 cycles.
  - RMW write: Nr+Nw+3 cycles.
  - illegal or zero-strobe write: 2 cycles.
- Cache request lines are mutually exclusive; at most one of read_C_L1I, read_C_L1D, write_C_L1D is high in any cycle.
- read_data holds its value until the next read completes.
- Timeout counter: 0 on entry to each wait state; increments each cycle while waiting.
  - When it reaches TIMEOUT: drop the cache request, set timeout_err, and go to RESP.
  - An aborted read returns read_data=32'h0.
- Cache ready or response pulses arriving in IDLE or RESP are ignored.
- Sticky flags clear only on reset.

Decomposition:
- Shared package holds: the FSM state encoding, default END_INST, the TIMEOUT default, and the strobe constants STRB_FULL=4'b1111 and STRB_NONE=4'b0000.
- One sub-module, store_byte_merge: combinational, inputs old word, new word and strobe; output is the merged word.

Test Plan:
- Read 0x100d8, L1I returns 32'h00000413 after 3 cycles -> read_C_L1I high 3 cycles, read_data=32'h00000413, one read_response pulse, L1D lines stay low.
- Store byte to 0x20004 with strobe 4'b0010, data 32'h0000AB00, L1D read returns 32'h11223344 -> write_C_L1D with data 32'h1122AB44, then one write_response.
- Store word to 0x20008 with strobe 4'b1111, data 32'hDEADBEEF -> no L1D read, write_data_C_L1=32'hDEADBEEF, response 2 cycles after write_response_L1D.
- Write to 0x11000 -> no cache request, illegal_write=1, write_response exactly 2 cycles after acceptance.
- read_request and write_request both high, address 0x20000 -> write completes first, then read is served; exactly one pulse of each response.
- L1D never asserts ready, TIMEOUT=16 -> read_C_L1D drops after 16 cycles, timeout_err=1, read_data=0.
- rstn low during RMW_RD -> all outputs 0 immediately, no response pulse; next request is served normally.
